// File: rtl/emergency_request_controller.sv
// emergency_request_controller
//
// Requester-side front end for traffic_system's emergency inputs. It
// synchronises and debounces three raw request sources, latches one pending
// request per high episode, and presents them to traffic_system one at a time
// in priority order (manual emergency > ambulance > police).
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   amb_req_raw   raw ambulance transponder request (asynchronous)
//   pol_req_raw   raw police transponder request (asynchronous)
//   man_emrg_raw  raw manual emergency switch (asynchronous)
//   ambulance     acknowledge from traffic_system: ambulance phase active
//   police        acknowledge from traffic_system: police phase active
//   alert1        ambulance request level (high while REQ_AMB)
//   alert2        police request level (high while REQ_POL)
//   emrg          emergency pulse, EMRG_PULSE cycles wide
//   busy          high whenever the controller is not IDLE
//   timeout_err   one-cycle pulse when an alert request times out
//   served_count  saturating count of acknowledged requests
module emergency_request_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int EMRG_PULSE      = 3,
    parameter int COOLDOWN_CYCLES = 2,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             amb_req_raw,
    input  logic             pol_req_raw,
    input  logic             man_emrg_raw,
    input  logic             ambulance,
    input  logic             police,
    output logic             alert1,
    output logic             alert2,
    output logic             emrg,
    output logic             busy,
    output logic             timeout_err,
    output logic [CNT_W-1:0] served_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int T_MAX0 = (TIMEOUT_CYCLES > EMRG_PULSE) ? TIMEOUT_CYCLES : EMRG_PULSE;
    localparam int T_MAX  = (T_MAX0 > COOLDOWN_CYCLES) ? T_MAX0 : COOLDOWN_CYCLES;
    localparam int TM_W   = $clog2(T_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_FULL = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [TM_W-1:0]  TO_LOAD = TM_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TM_W-1:0]  EP_LOAD = TM_W'(EMRG_PULSE - 1);
    localparam logic [TM_W-1:0]  CD_LOAD = TM_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Request index: 0 = manual emergency, 1 = ambulance, 2 = police.
    localparam int IX_EMRG = 0;
    localparam int IX_AMB  = 1;
    localparam int IX_POL  = 2;

    typedef enum logic [2:0] {
        IDLE,
        REQ_AMB,
        REQ_POL,
        EMRG_P,
        COOLDOWN
    } state_t;

    logic [2:0]      raw;
    logic [2:0]      sync_a;
    logic [2:0]      sync_b;
    logic [1:0]      fill;
    logic [2:0]      armed;
    logic [2:0]      pending;
    logic [2:0]      pend_clr;
    logic [DB_W-1:0] db_cnt [3];

    state_t          state;
    state_t          state_nx;
    logic [TM_W-1:0] timer;
    logic [TM_W-1:0] timer_nx;
    logic            served_inc;
    logic            timeout_nx;

    assign raw = {pol_req_raw, amb_req_raw, man_emrg_raw};

    // 2-FF synchronisers. fill marks when sync_b carries a real sample
    // rather than its reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= '0;
            sync_b <= '0;
            fill   <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            fill   <= {fill[0], 1'b1};
        end
    end

    // Debounce and pending latch. An input is only armed once it has been
    // seen low after reset, so a request held high through reset is not
    // re-issued until it goes low and high again. The counter saturates at
    // DEBOUNCE_CYCLES so each high episode latches exactly once; a new latch
    // takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed   <= '0;
            pending <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (fill[1] && !sync_b[i]) begin
                    armed[i] <= 1'b1;
                end
                if (!sync_b[i]) begin
                    db_cnt[i] <= '0;
                end else if (armed[i] && db_cnt[i] != DB_FULL) begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
                if (sync_b[i] && armed[i] && db_cnt[i] == DB_LAST) begin
                    pending[i] <= 1'b1;
                end else if (pend_clr[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Next-state logic. In the alert states an acknowledge beats a timeout,
    // and both beat an emergency preemption; a preempted request keeps its
    // pending flag and gets a fresh timer when it is re-entered from IDLE.
    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        pend_clr   = '0;
        served_inc = 1'b0;
        timeout_nx = 1'b0;
        case (state)
            IDLE: begin
                if (pending[IX_EMRG]) begin
                    state_nx = EMRG_P;
                    timer_nx = EP_LOAD;
                end else if (pending[IX_AMB]) begin
                    state_nx = REQ_AMB;
                    timer_nx = TO_LOAD;
                end else if (pending[IX_POL]) begin
                    state_nx = REQ_POL;
                    timer_nx = TO_LOAD;
                end
            end
            REQ_AMB: begin
                if (ambulance) begin
                    pend_clr[IX_AMB] = 1'b1;
                    served_inc       = 1'b1;
                    state_nx         = COOLDOWN;
                    timer_nx         = CD_LOAD;
                end else if (timer == '0) begin
                    pend_clr[IX_AMB] = 1'b1;
                    timeout_nx       = 1'b1;
                    state_nx         = COOLDOWN;
                    timer_nx         = CD_LOAD;
                end else if (pending[IX_EMRG]) begin
                    state_nx = EMRG_P;
                    timer_nx = EP_LOAD;
                end else begin
                    timer_nx = timer - TM_W'(1);
                end
            end
            REQ_POL: begin
                if (police) begin
                    pend_clr[IX_POL] = 1'b1;
                    served_inc       = 1'b1;
                    state_nx         = COOLDOWN;
                    timer_nx         = CD_LOAD;
                end else if (timer == '0) begin
                    pend_clr[IX_POL] = 1'b1;
                    timeout_nx       = 1'b1;
                    state_nx         = COOLDOWN;
                    timer_nx         = CD_LOAD;
                end else if (pending[IX_EMRG]) begin
                    state_nx = EMRG_P;
                    timer_nx = EP_LOAD;
                end else begin
                    timer_nx = timer - TM_W'(1);
                end
            end
            EMRG_P: begin
                if (timer == '0) begin
                    pend_clr[IX_EMRG] = 1'b1;
                    state_nx          = COOLDOWN;
                    timer_nx          = CD_LOAD;
                end else begin
                    timer_nx = timer - TM_W'(1);
                end
            end
            COOLDOWN: begin
                if (timer == '0) begin
                    state_nx = IDLE;
                end else begin
                    timer_nx = timer - TM_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
            end
        endcase
    end

    // State register and registered outputs, decoded from the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            timer        <= '0;
            alert1       <= 1'b0;
            alert2       <= 1'b0;
            emrg         <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            served_count <= '0;
        end else begin
            state       <= state_nx;
            timer       <= timer_nx;
            alert1      <= (state_nx == REQ_AMB);
            alert2      <= (state_nx == REQ_POL);
            emrg        <= (state_nx == EMRG_P);
            busy        <= (state_nx != IDLE);
            timeout_err <= timeout_nx;
            if (served_inc && served_count != CNT_MAX) begin
                served_count <= served_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_emergency_request_controller.sv
// Directed testbench for emergency_request_controller at default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_emergency_request_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       amb_req_raw;
    logic       pol_req_raw;
    logic       man_emrg_raw;
    logic       ambulance;
    logic       police;
    logic       alert1;
    logic       alert2;
    logic       emrg;
    logic       busy;
    logic       timeout_err;
    logic [7:0] served_count;

    int n_cmp = 0;
    int n_bad = 0;
    int to_cnt = 0;

    emergency_request_controller dut (
        .clk          (clk),
        .rst          (rst),
        .amb_req_raw  (amb_req_raw),
        .pol_req_raw  (pol_req_raw),
        .man_emrg_raw (man_emrg_raw),
        .ambulance    (ambulance),
        .police       (police),
        .alert1       (alert1),
        .alert2       (alert2),
        .emrg         (emrg),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .served_count (served_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (timeout_err) to_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic sel(input int w);
        case (w)
            1: return alert1;
            2: return alert2;
            default: return emrg;
        endcase
    endfunction

    // Wait (bounded) until the selected output is high.
    task automatic wait_for(input int which, input int budget, input string tag);
        int n = 0;
        while (!sel(which) && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(sel(which)), 1);
    endtask

    // Count the falling-edge samples for which the selected output stays high.
    task automatic width_of(input int which, output int n);
        n = 0;
        while (sel(which) && n < 200) begin
            n++;
            tick(1);
        end
    endtask

    initial begin
        int n;
        int gap;
        int seen;
        int base;
        int to_base;

        rst = 1'b0;
        amb_req_raw = 1'b0;
        pol_req_raw = 1'b0;
        man_emrg_raw = 1'b0;
        ambulance = 1'b0;
        police = 1'b0;
        tick(2);
        check("rst_alert1", 32'(alert1), 0);
        check("rst_alert2", 32'(alert2), 0);
        check("rst_emrg", 32'(emrg), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        check("rst_served", 32'(served_count), 0);
        rst = 1'b1;
        tick(5);

        // 1: ambulance request with no acknowledge -> timeout
        to_cnt = 0;
        amb_req_raw = 1'b1;
        tick(6);
        check("t1_edge6_low", 32'(alert1), 0);
        tick(1);
        check("t1_edge7_high", 32'(alert1), 1);
        width_of(1, n);
        check("t1_width", 32'(n), 64);
        check("t1_timeout_pulse", 32'(timeout_err), 1);
        tick(1);
        check("t1_timeout_one_cycle", 32'(timeout_err), 0);
        check("t1_timeout_count", 32'(to_cnt), 1);
        check("t1_served", 32'(served_count), 0);
        amb_req_raw = 1'b0;
        tick(4);
        check("t1_idle", 32'(busy), 0);

        // 2: police request acknowledged after alert2 has been high 4 cycles
        pol_req_raw = 1'b1;
        wait_for(2, 20, "t2_alert2_rise");
        n = 0;
        while (alert2 && n < 100) begin
            n++;
            if (n == 4) police = 1'b1;
            tick(1);
        end
        police = 1'b0;
        pol_req_raw = 1'b0;
        check("t2_width", 32'(n), 4);
        check("t2_served", 32'(served_count), 1);
        tick(1);
        check("t2_busy_cool", 32'(busy), 1);
        tick(1);
        check("t2_busy_idle", 32'(busy), 0);
        tick(3);

        // 3: 3-cycle glitch is rejected, 4-cycle pulse is accepted
        amb_req_raw = 1'b1;
        tick(3);
        amb_req_raw = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (alert1 || busy) seen = 1;
            tick(1);
        end
        check("t3_glitch_ignored", 32'(seen), 0);
        amb_req_raw = 1'b1;
        tick(4);
        amb_req_raw = 1'b0;
        wait_for(1, 20, "t3_four_cycle_latch");
        ambulance = 1'b1;
        tick(1);
        ambulance = 1'b0;
        check("t3_served", 32'(served_count), 2);
        tick(5);

        // 4: all three requests at once, served in priority order
        base = int'(served_count);
        amb_req_raw = 1'b1;
        pol_req_raw = 1'b1;
        man_emrg_raw = 1'b1;
        wait_for(0, 20, "t4_emrg_first");
        check("t4_no_alert_in_emrg", 32'({alert1, alert2}), 0);
        width_of(0, n);
        check("t4_emrg_width", 32'(n), 3);
        gap = 0;
        while (!alert1 && gap < 20) begin
            gap++;
            tick(1);
        end
        check("t4_alert1_second", 32'(alert1), 1);
        check("t4_gap1_ge_cool", 32'(gap >= 2 && gap < 20), 1);
        check("t4_alert2_waits", 32'(alert2), 0);
        ambulance = 1'b1;
        tick(1);
        ambulance = 1'b0;
        gap = 0;
        while (!alert2 && gap < 20) begin
            gap++;
            tick(1);
        end
        check("t4_alert2_third", 32'(alert2), 1);
        check("t4_gap2_ge_cool", 32'(gap >= 2 && gap < 20), 1);
        police = 1'b1;
        tick(1);
        police = 1'b0;
        check("t4_served_delta", 32'(int'(served_count) - base), 2);
        amb_req_raw = 1'b0;
        pol_req_raw = 1'b0;
        man_emrg_raw = 1'b0;
        tick(5);
        check("t4_idle", 32'(busy), 0);

        // 5: emergency preempts an active ambulance request
        base = int'(served_count);
        to_base = to_cnt;
        amb_req_raw = 1'b1;
        wait_for(1, 20, "t5_alert1_rise");
        man_emrg_raw = 1'b1;
        wait_for(0, 20, "t5_emrg_preempt");
        check("t5_alert1_dropped", 32'(alert1), 0);
        width_of(0, n);
        check("t5_emrg_width", 32'(n), 3);
        wait_for(1, 20, "t5_alert1_reassert");
        ambulance = 1'b1;
        tick(1);
        ambulance = 1'b0;
        check("t5_served_delta", 32'(int'(served_count) - base), 1);
        check("t5_no_timeout", 32'(to_cnt - to_base), 0);
        amb_req_raw = 1'b0;
        man_emrg_raw = 1'b0;
        tick(5);

        // 6: asynchronous reset in the middle of a police request
        to_base = to_cnt;
        pol_req_raw = 1'b1;
        wait_for(2, 20, "t6_alert2_rise");
        tick(2);
        #2 rst = 1'b0;
        #1;
        check("t6_alert2_async", 32'(alert2), 0);
        check("t6_busy_async", 32'(busy), 0);
        check("t6_served_async", 32'(served_count), 0);
        check("t6_timeout_async", 32'(timeout_err), 0);
        tick(1);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (alert2 || busy || timeout_err) seen = 1;
            tick(1);
        end
        check("t6_no_reissue", 32'(seen), 0);
        check("t6_no_timeout", 32'(to_cnt - to_base), 0);
        pol_req_raw = 1'b0;
        tick(3);
        pol_req_raw = 1'b1;
        wait_for(2, 20, "t6_rearmed");
        pol_req_raw = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
